// File: rtl/video_ctrl_pkg.sv
// rtl/video_ctrl_pkg.sv - display mode encoding, raster widths and mode helpers
package video_ctrl_pkg;

   typedef enum logic [1:0] {
      CAMERA      = 2'd0,
      CHANNEL     = 2'd1,
      CHANNEL_TGT = 2'd2,
      CAMERA_TGT  = 2'd3
   } mode_t;

   localparam int HCOUNT_W             = 11;
   localparam int VCOUNT_W             = 10;
   localparam int H_ACTIVE_DEFAULT     = 1280;
   localparam int V_ACTIVE_DEFAULT     = 720;
   localparam int STALE_FRAMES_DEFAULT = 8;
   localparam int BLINK_FRAMES_DEFAULT = 15;

   function automatic mode_t next_mode(input mode_t m);
      case (m)
         CAMERA:      return CHANNEL;
         CHANNEL:     return CHANNEL_TGT;
         CHANNEL_TGT: return CAMERA_TGT;
         default:     return CAMERA;
      endcase
   endfunction

   function automatic logic mode_bg(input mode_t m);
      return (m == CHANNEL) || (m == CHANNEL_TGT);
   endfunction

   function automatic logic mode_tgt(input mode_t m);
      return (m == CHANNEL_TGT) || (m == CAMERA_TGT);
   endfunction

endpackage

// File: rtl/crosshair_gen.sv
// rtl/crosshair_gen.sv - registered crosshair strobe; blink gating under CROSSHAIR_BLINK_EN
module crosshair_gen
   import video_ctrl_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
   parameter int V_ACTIVE = V_ACTIVE_DEFAULT
`ifdef CROSSHAIR_BLINK_EN
  ,parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
`endif
)(
   input  logic                clk_i,
   input  logic                rst_i,
`ifdef CROSSHAIR_BLINK_EN
   input  logic                frame_tick_i,
`endif
   input  logic                enable_i,
   input  logic [HCOUNT_W-1:0] hcount_i,
   input  logic [VCOUNT_W-1:0] vcount_i,
   input  logic [HCOUNT_W-1:0] tx_i,
   input  logic [VCOUNT_W-1:0] ty_i,
   output logic                crosshair_o
);

   localparam logic [HCOUNT_W-1:0] H_LIM = HCOUNT_W'(H_ACTIVE);
   localparam logic [VCOUNT_W-1:0] V_LIM = VCOUNT_W'(V_ACTIVE);

   logic blink_on;
   logic cross_q, cross_d;

`ifdef CROSSHAIR_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_on_q, blink_on_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
      end
   end

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      if (frame_tick_i) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   assign blink_on = blink_on_q;
`else
   assign blink_on = 1'b1;
`endif

   // Out-of-range tx/ty can never equal an active coordinate, so that axis draws nothing.
   always_comb begin
      cross_d = enable_i & blink_on
              & (hcount_i < H_LIM) & (vcount_i < V_LIM)
              & ((hcount_i == tx_i) | (vcount_i == ty_i));
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cross_q <= 1'b0;
      else       cross_q <= cross_d;
   end

   assign crosshair_o = cross_q;

endmodule

// File: rtl/video_mode_ctrl.sv
// rtl/video_mode_ctrl.sv - frame-synchronous display mode sequencer with target latch; CROSSHAIR_BLINK_EN enables blink
module video_mode_ctrl
   import video_ctrl_pkg::*;
#(
   parameter int H_ACTIVE     = H_ACTIVE_DEFAULT,
   parameter int V_ACTIVE     = V_ACTIVE_DEFAULT,
   parameter int STALE_FRAMES = STALE_FRAMES_DEFAULT
`ifdef CROSSHAIR_BLINK_EN
  ,parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
`endif
)(
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                mode_btn_in,
   input  logic                new_frame_in,
   input  logic [HCOUNT_W-1:0] hcount_in,
   input  logic [VCOUNT_W-1:0] vcount_in,
   input  logic [HCOUNT_W-1:0] target_x_in,
   input  logic [VCOUNT_W-1:0] target_y_in,
   input  logic                target_valid_in,
   output mode_t               mode_out,
   output logic                bg_out,
   output logic                target_out,
   output logic                crosshair_out
);

   localparam int SW = $clog2(STALE_FRAMES + 1);
   localparam logic [SW-1:0] STALE_MAX = SW'(STALE_FRAMES);

   mode_t               mode_q, mode_d;
   mode_t               pending_q, pending_d;
   logic                bg_q, bg_d;
   logic                tgt_q, tgt_d;
   logic [HCOUNT_W-1:0] tx_q, tx_d;
   logic [VCOUNT_W-1:0] ty_q, ty_d;
   logic                tracked_q, tracked_d;
   logic [SW-1:0]       stale_q, stale_d;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mode_q    <= CAMERA;
         pending_q <= CAMERA;
         bg_q      <= 1'b0;
         tgt_q     <= 1'b0;
         tx_q      <= '0;
         ty_q      <= '0;
         tracked_q <= 1'b0;
         stale_q   <= '0;
      end else begin
         mode_q    <= mode_d;
         pending_q <= pending_d;
         bg_q      <= bg_d;
         tgt_q     <= tgt_d;
         tx_q      <= tx_d;
         ty_q      <= ty_d;
         tracked_q <= tracked_d;
         stale_q   <= stale_d;
      end
   end

   // A press coinciding with new_frame_in commits the old pending value and lands next frame.
   always_comb begin
      mode_d    = mode_q;
      pending_d = pending_q;
      bg_d      = mode_bg(mode_q);
      tgt_d     = mode_tgt(mode_q);
      tx_d      = tx_q;
      ty_d      = ty_q;
      tracked_d = tracked_q;
      stale_d   = stale_q;

      if (mode_btn_in)
         pending_d = next_mode(pending_q);

      if (new_frame_in) begin
         mode_d = pending_q;
         if (target_valid_in) begin
            tx_d      = target_x_in;
            ty_d      = target_y_in;
            tracked_d = 1'b1;
            stale_d   = '0;
         end else if (stale_q != STALE_MAX) begin
            stale_d = stale_q + 1'b1;
            if (stale_d == STALE_MAX)
               tracked_d = 1'b0;
         end
      end
   end

   crosshair_gen #(
      .H_ACTIVE     (H_ACTIVE),
      .V_ACTIVE     (V_ACTIVE)
`ifdef CROSSHAIR_BLINK_EN
     ,.BLINK_FRAMES (BLINK_FRAMES)
`endif
   ) u_crosshair (
      .clk_i        (clk_in),
      .rst_i        (rst_in),
`ifdef CROSSHAIR_BLINK_EN
      .frame_tick_i (new_frame_in),
`endif
      .enable_i     (tgt_q & tracked_q),
      .hcount_i     (hcount_in),
      .vcount_i     (vcount_in),
      .tx_i         (tx_q),
      .ty_i         (ty_q),
      .crosshair_o  (crosshair_out)
   );

   assign mode_out   = mode_q;
   assign bg_out     = bg_q;
   assign target_out = tgt_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb/tb_video_mode_ctrl.sv - randomized self-checking bench for video_mode_ctrl against a frame-level model
module tb_video_mode_ctrl;
   import video_ctrl_pkg::*;

   localparam int H     = 1280;
   localparam int V     = 720;
   localparam int STALE = 8;
   localparam int BLINK = 2;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        mode_btn_in;
   logic        new_frame_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [10:0] target_x_in;
   logic [9:0]  target_y_in;
   logic        target_valid_in;
   mode_t       mode_out;
   logic        bg_out;
   logic        target_out;
   logic        crosshair_out;

   always #5 clk_in = ~clk_in;

   video_mode_ctrl #(
      .H_ACTIVE     (H),
      .V_ACTIVE     (V),
      .STALE_FRAMES (STALE)
`ifdef CROSSHAIR_BLINK_EN
     ,.BLINK_FRAMES (BLINK)
`endif
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .mode_btn_in     (mode_btn_in),
      .new_frame_in    (new_frame_in),
      .hcount_in       (hcount_in),
      .vcount_in       (vcount_in),
      .target_x_in     (target_x_in),
      .target_y_in     (target_y_in),
      .target_valid_in (target_valid_in),
      .mode_out        (mode_out),
      .bg_out          (bg_out),
      .target_out      (target_out),
      .crosshair_out   (crosshair_out)
   );

   // Reference model: mode index 0..3 in cyclic order, shown = mode visible on the mux selects.
   int m_pend, m_mode, m_shown, m_tx, m_ty, m_miss, m_frames;
   bit m_tracked, m_cross;
   int n_checks = 0;
   int n_fail   = 0;

   function automatic bit bg_of(input int m);
      return (m == 1) || (m == 2);
   endfunction

   function automatic bit tg_of(input int m);
      return (m == 2) || (m == 3);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend = 0; m_mode = 0; m_shown = 0; m_tx = 0; m_ty = 0;
      m_miss = 0; m_frames = 0; m_tracked = 0; m_cross = 0;
   endtask

   task automatic check_outputs(input string tag);
      check_eq({tag, "_mode"},  32'(mode_out),      32'(m_mode));
      check_eq({tag, "_bg"},    32'(bg_out),        32'(bg_of(m_shown)));
      check_eq({tag, "_tgt"},   32'(target_out),    32'(tg_of(m_shown)));
      check_eq({tag, "_cross"}, 32'(crosshair_out), 32'(m_cross));
   endtask

   task automatic step(input bit b, input bit f, input bit vld,
                       input int h, input int v, input int tx, input int ty);
      bit blink;
      mode_btn_in     = b;
      new_frame_in    = f;
      target_valid_in = vld;
      hcount_in       = 11'(h);
      vcount_in       = 10'(v);
      target_x_in     = 11'(tx);
      target_y_in     = 10'(ty);
      @(posedge clk_in);
`ifdef CROSSHAIR_BLINK_EN
      blink = ((m_frames / BLINK) % 2) == 0;
`else
      blink = 1'b1;
`endif
      m_cross = tg_of(m_shown) && m_tracked && blink && (h < H) && (v < V)
                && ((h == m_tx) || (v == m_ty));
      m_shown = m_mode;
      if (f) begin
         m_mode = m_pend;
         m_frames++;
         if (vld) begin
            m_tx = tx; m_ty = ty; m_tracked = 1; m_miss = 0;
         end else if (m_miss < STALE) begin
            m_miss++;
            if (m_miss == STALE) m_tracked = 0;
         end
      end
      if (b) m_pend = (m_pend + 1) % 4;
      #1;
      check_outputs("step");
   endtask

   task automatic idle(input int h, input int v);
      step(0, 0, 0, h, v, 0, 0);
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      #1;
      model_reset();
      check_eq("rst_mode",  32'(mode_out),      0);
      check_eq("rst_bg",    32'(bg_out),        0);
      check_eq("rst_tgt",   32'(target_out),    0);
      check_eq("rst_cross", 32'(crosshair_out), 0);
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      check_eq("rst_release_mode", 32'(mode_out), 32'(CAMERA));
   endtask

   function automatic int pick_h();
      case ($urandom_range(0, 5))
         0:       return m_tx;
         1:       return m_tx + 1;
         2:       return H - 1;
         3:       return H;
         4:       return int'($urandom_range(0, 2047));
         default: return 0;
      endcase
   endfunction

   function automatic int pick_v();
      case ($urandom_range(0, 5))
         0:       return m_ty;
         1:       return m_ty - 1;
         2:       return V - 1;
         3:       return V;
         4:       return int'($urandom_range(0, 1023));
         default: return 0;
      endcase
   endfunction

   int scan_h[11] = '{640, 641, 639, 100, 640, 1280, 640, 2047, 0,    1279, 640};
   int scan_v[11] = '{100, 100, 360, 360, 720, 360,  1000, 360, 0,    719,  719};
   bit scan_e[11] = '{1,   0,   1,   1,   0,   0,    0,    0,   0,    0,    1};

   initial begin
      rst_in = 1'b1;
      mode_btn_in = 0; new_frame_in = 0; target_valid_in = 0;
      hcount_in = 0; vcount_in = 0; target_x_in = 0; target_y_in = 0;
      model_reset();
      repeat (2) @(posedge clk_in);
      #1;
      check_outputs("reset");
      rst_in = 1'b0;

      // single press mid-frame, committed at the frame boundary
      idle(10, 10); idle(20, 10);
      step(1, 0, 0, 30, 10, 0, 0);
      idle(40, 10); idle(50, 10);
      check_eq("t2_bg_pre", 32'(bg_out), 0);
      step(0, 1, 0, H, V, 0, 0);
      check_eq("t2_mode_commit", 32'(mode_out), 32'(CHANNEL));
      idle(0, V);
      check_eq("t2_bg_post", 32'(bg_out), 1);

      // reset mid-run
      idle(5, 5);
      do_reset();

      // press coincident with commit
      step(1, 1, 0, H, V, 0, 0);
      check_eq("t3_same_cycle", 32'(mode_out), 32'(CAMERA));
      idle(1, 1); idle(2, 2);
      step(0, 1, 0, H, V, 0, 0);
      check_eq("t3_next_frame", 32'(mode_out), 32'(CHANNEL));

      do_reset();
      for (int i = 0; i < 5; i++) step(1, 0, 0, i, 3, 0, 0);
      step(0, 1, 0, H, V, 0, 0);
      check_eq("t3_five_wrap", 32'(mode_out), 32'(CHANNEL));

      // crosshair at 640/360 in CHANNEL_TGT
      do_reset();
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, H, V, 640, 360);
      check_eq("t4_mode", 32'(mode_out), 32'(CHANNEL_TGT));
      idle(0, V);
      for (int i = 0; i < 11; i++) begin
         step(0, 0, 0, scan_h[i], scan_v[i], 0, 0);
         check_eq("t4_scan", 32'(crosshair_out), 32'(scan_e[i]));
      end

      // stale tracking: 7 missing frames keep it, the 8th drops it, one valid restores
      for (int f = 0; f < STALE; f++) begin
         idle(640, 50); idle(10, 360); idle(H, 360);
         step(0, 1, 0, H, V, 0, 0);
      end
      idle(640, 50);
      check_eq("t5_dropped", 32'(crosshair_out), 0);
      step(0, 1, 1, H, V, 640, 360);
      for (int i = 0; i < 4; i++) idle(640, 50 + i);

      // randomized frames
      for (int f = 0; f < 60; f++) begin
         int len;
         len = int'($urandom_range(8, 30));
         for (int c = 0; c < len; c++)
            step($urandom_range(0, 9) == 0, 0, 0, pick_h(), pick_v(), 0, 0);
         step($urandom_range(0, 3) == 0, 1, $urandom_range(0, 9) < 4,
              H, V, int'($urandom_range(0, 1400)), int'($urandom_range(0, 800)));
         if ($urandom_range(0, 19) == 0) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
